// File: rtl/grid_claim_arbiter_if.sv
// Requester and grid-RAM signal bundle for grid_claim_arbiter.
// slave is the arbiter's view; master is the engines-plus-RAM side.
interface grid_claim_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      op;
    logic [ADDR_W*NREQ-1:0] addr;
    logic [DATA_W*NREQ-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   claim_ok;
    logic                   mem_re;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_din;
    logic [DATA_W-1:0]      mem_dout;

    modport slave (
        input  req, op, addr, wdata, mem_dout,
        output gnt, done, rdata, claim_ok, mem_re, mem_we, mem_addr, mem_din
    );

    modport master (
        output req, op, addr, wdata, mem_dout,
        input  gnt, done, rdata, claim_ok, mem_re, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/grid_claim_arbiter.sv
// Round-robin arbiter serialising read, write and atomic claim transactions
// from NREQ placement engines onto a single grid RAM port.
module grid_claim_arbiter #(
    parameter int                NREQ   = 4,
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] EMPTY  = {DATA_W{1'b1}}
) (
    input logic                 clk,
    input logic                 reset,
    grid_claim_arbiter_if.slave bus
);
    localparam int         PTR_W    = $clog2(NREQ);
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              claim_ok_q, claim_ok_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

    logic [1:0]        op_arr    [NREQ];
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];
    logic              sel_found;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W-1:0]  cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi]    = bus.op[2*gi +: 2];
        assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] k);
        onehot    = '0;
        onehot[k] = 1'b1;
    endfunction

    // Scan starts one past the last winner so every waiting engine is reached
    // within NREQ transactions.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_d      = '0;
        done_d     = '0;
        rdata_d    = rdata_q;
        claim_ok_d = claim_ok_q;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        unique case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    ptr_d   = sel_idx;
                    op_d    = op_arr[sel_idx];
                    addr_d  = addr_arr[sel_idx];
                    wdata_d = wdata_arr[sel_idx];
                    gnt_d   = onehot(sel_idx);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr_d = addr_q;
                if (op_q == OP_WRITE) begin
                    mem_we_d  = 1'b1;
                    mem_din_d = wdata_q;
                    done_d    = onehot(idx_q);
                    state_d   = S_DONE;
                end else begin
                    mem_re_d = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // The conditional write lands on the cycle right after the read
                // data arrives, so no other transaction can slip in between.
                rdata_d    = bus.mem_dout;
                claim_ok_d = 1'b0;
                if (op_q == OP_CLAIM && bus.mem_dout == EMPTY) begin
                    mem_we_d   = 1'b1;
                    mem_din_d  = wdata_q;
                    claim_ok_d = 1'b1;
                end
                done_d  = onehot(idx_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_W'(NREQ - 1);
            idx_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            claim_ok_q <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            claim_ok_q <= claim_ok_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.claim_ok = claim_ok_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
endmodule

// File: doc/grid_claim_arbiter.md
# grid_claim_arbiter

Round-robin arbiter that shares one grid `memoryRAM` port among `NREQ` placement engines. It serialises their read, write and atomic claim transactions. A claim reads a grid cell and writes the requester's node id only if the cell is still empty (-1). This lets several placement engines try offsets concurrently without two nodes landing on the same cell. The block sits between the engines and the grid RAM and owns all of the RAM's control signals.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `ADDR_W`, 32: grid address width.
- `DATA_W`, 32: grid data width.
- `EMPTY`, 32'hFFFFFFFF: empty-cell marker (-1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `op`  in  2*NREQ  op of requester k at [2k+:2]: 00 read, 01 write, 10 claim, 11 treated as read.
- `addr`  in  ADDR_W*NREQ  address of requester k at [k*ADDR_W+:ADDR_W].
- `wdata`  in  DATA_W*NREQ  write/claim data of requester k, same packing.
- `gnt`  out  NREQ  one-hot, 1-cycle pulse on acceptance.
- `done`  out  NREQ  one-hot, 1-cycle pulse on completion.
- `rdata`  out  DATA_W  cell value read, valid while `done` is high (read/claim).
- `claim_ok`  out  1  claim succeeded, valid while `done` is high.
- `mem_re`, `mem_we`  out  1  grid RAM read and write strobes.
- `mem_addr`  out  ADDR_W  grid RAM address.
- `mem_din`  out  DATA_W  grid RAM write data.
- `mem_dout`  in  DATA_W  grid RAM read data, valid the cycle after `mem_re` is high.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE. All outputs are registered.
- **IDLE**
  - If any `req` bit is set, pick the first requester at or after `ptr+1` (mod NREQ).
  - Latch its op, addr and wdata; set `gnt[k]`; set `ptr<=k`; go to ISSUE.
  - If no `req` bit is set, stay in IDLE.
- **ISSUE**
  - Write: `mem_we<=1`, `mem_addr<=addr`, `mem_din<=wdata`; go to DONE.
  - Read or claim: `mem_re<=1`, `mem_addr<=addr`; go to WAIT.
- **WAIT**: go to CHECK. The RAM is producing data during this cycle.
- **CHECK**
  - Always: `rdata<=mem_dout`.
  - Claim with `mem_dout==EMPTY`: `mem_we<=1`, `mem_din<=wdata`, `claim_ok<=1`.
  - Claim with any other value: `claim_ok<=0`; no write.
  - Read: `claim_ok<=0`.
  - Go to DONE.
- **DONE**: `done[k]` is high; go to IDLE.
- Read data is compared as all DATA_W bits against EMPTY (no sign handling).
- Addresses are passed through unchecked. Requesters are responsible for grid bounds.
- A requester holds `req`, `op`, `addr` and `wdata` stable until it sees `gnt`, then deasserts `req` in the next cycle. `req` is sampled only in IDLE.
- `rdata` and `claim_ok` keep their value after DONE until the next CHECK.
- `mem_re` and `mem_we` are single-cycle pulses and are never high together.

## Timing
- Cycle 0 is the IDLE cycle that samples `req`.
  - Read/claim: `gnt` in cycle 1, `mem_re` in cycle 2, `mem_dout` sampled in cycle 3.
  - Read/claim: `done`, `rdata` and `claim_ok` in cycle 4, plus the claim `mem_we` in cycle 4.
  - Next arbitration is in cycle 5.
  - Write: `gnt` in cycle 1, `mem_we` and `done` in cycle 2, next arbitration in cycle 3.
- Throughput: one read/claim per 5 cycles, one write per 3 cycles.
- Simultaneous requests: round-robin order. A waiting requester is served within NREQ transactions.
- Claim atomicity: no other transaction reaches the RAM between a claim's read and its write.
- Reset assertion, at any time, asynchronously forces:
  - state IDLE, `ptr=NREQ-1` (requester 0 has priority after reset);
  - `gnt`, `done`, `rdata`, `claim_ok`, `mem_re`, `mem_we`, `mem_addr`, `mem_din` all 0.
  - An in-flight transaction is abandoned: no `done`, no write.

## Test plan
- Single read: req0, op=00, addr=23, cell 23 holds 5 -> `gnt`=0001 in cycle 1, `mem_re` in cycle 2, `done`=0001 with `rdata`=5 in cycle 4.
- Claim empty: req1, op=10, addr=7, wdata=3, cell 7 = -1 -> `mem_we` with `mem_din`=3 in cycle 4, `claim_ok`=1; a later read of cell 7 returns 3.
- Claim occupied: req2 claims addr=7, wdata=9 after the previous test -> `claim_ok`=0, `rdata`=3, no `mem_we`, cell 7 still 3.
- Race: req0 and req1 both claim addr=12 (empty) in the same cycle, wdata 4 and 6 -> req0 served first with `claim_ok`=1; req1 gets `claim_ok`=0 and `rdata`=4.
- Round-robin: all four requesters assert writes continuously (re-raising `req` after each `done`) -> grant order 0,1,2,3,0, with `gnt` pulses 3 cycles apart.
- Reset mid-claim: assert reset in cycle 3 of a claim on an empty cell -> all outputs 0 immediately, no `mem_we`, cell still -1; after release req0 wins first.
